output_sram_arbiter: RTL

OUTPUT_SRAM_ARBITER -- requirements
Module: output_sram_arbiter

---
 rtl/osram_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/output_sram_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/osram_pkg.sv
// ---------------------------------------------------------------------------
// osram_pkg
// Purpose : Shared definitions for the output SRAM arbiter: FSM state
//           encoding, bank-field geometry, the reader starvation limit and
//           a helper that classifies an out-of-range bank.
// Contents: osram_state_e, BANK_LSB, BANK_MSB, NUM_BANKS, STARVE_LIMIT,
//           bank_is_bad().
// ---------------------------------------------------------------------------
package osram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } osram_state_e;

    localparam int BANK_LSB     = 11;
    localparam int BANK_MSB     = 13;
    localparam int NUM_BANKS    = 6;
    localparam int STARVE_LIMIT = 4;

    // Banks 6 and 7 are not populated in the output SRAM.
    function automatic logic bank_is_bad(input logic [BANK_MSB-BANK_LSB:0] bank);
        return (bank >= (BANK_MSB-BANK_LSB+1)'(NUM_BANKS));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purpose : Round-robin one-hot grant among NUM_WR requesters. The search
//           starts at the internal pointer; when i_advance is asserted and a
//           grant exists the pointer moves to (winner + 1) mod NUM_WR.
// Ports   : clock, reset  - clock, synchronous active-high reset
//           i_req         - per-requester request vector
//           i_advance     - commit the current grant (move the pointer)
//           o_grant       - one-hot grant (all zero when nothing requests)
//           o_any         - at least one requester is asserting
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_WR = 4,
    localparam int IDX_W  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_WR-1:0] i_req,
    input  logic              i_advance,
    output logic [NUM_WR-1:0] o_grant,
    output logic              o_any
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        int   v_pos;
        logic v_found;
        v_pos   = 0;
        v_found = 1'b0;
        o_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            v_pos = (int'(r_ptr) + k) % NUM_WR;
            if (!v_found && i_req[v_pos]) begin
                v_found        = 1'b1;
                o_grant[v_pos] = 1'b1;
                w_idx          = IDX_W'(v_pos);
            end
        end
        o_any = v_found;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_advance && o_any) begin
            r_ptr <= (w_idx == IDX_W'(NUM_WR-1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/output_sram_arbiter.sv
// ---------------------------------------------------------------------------
// output_sram_arbiter
// Purpose : Serialises NUM_WR PE output writers and one drain reader onto a
//           single-outstanding SRAM controller port. Writers are served
//           round-robin; the reader is served when no writer requests, or
//           with priority once it has been passed over STARVE_LIMIT times.
//           Requests to banks >= NUM_BANKS are not issued; they complete
//           immediately with addr_err.
// Config  : define OSRAM_ARB_PERF_CNT_EN to add saturating 32-bit counters
//           perf_wr_cnt / perf_rd_cnt / perf_stall_cnt.
// Ports   : clock, reset            - clock, synchronous active-high reset
//           wr_req/wr_addr/wr_data  - per-writer request, packed addr/data
//           wr_done                 - per-writer one-cycle completion pulse
//           rd_req/rd_addr          - drain reader request and address
//           rd_data/rd_valid        - read data, one-cycle valid pulse
//           addr_err                - pulse: granted request hit a bad bank
//           sram_*                  - SRAM controller operands/strobes/responses
// ---------------------------------------------------------------------------
module output_sram_arbiter
    import osram_pkg::*;
#(
    parameter int NUM_WR = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        wr_req,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [NUM_WR-1:0]        wr_done,
    input  logic                     rd_req,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     addr_err,
    output logic [ADDR_W-1:0]        sram_w_addr,
    output logic [ADDR_W-1:0]        sram_r_addr,
    output logic [DATA_W-1:0]        sram_w_d,
    output logic                     sram_w_en,
    output logic                     sram_r_en,
    input  logic [DATA_W-1:0]        sram_r_d,
    input  logic                     sram_d_ready,
    input  logic                     sram_w_done
`ifdef OSRAM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]              perf_wr_cnt,
    output logic [31:0]              perf_rd_cnt,
    output logic [31:0]              perf_stall_cnt
`endif
);

    function automatic logic [2:0] starve_inc(input logic [2:0] v);
        return (v >= 3'(STARVE_LIMIT)) ? 3'(STARVE_LIMIT) : v + 3'd1;
    endfunction

    osram_state_e r_state;
    osram_state_e w_next_state;

    logic [NUM_WR-1:0] r_win_oh;
    logic              r_is_rd;
    logic [ADDR_W-1:0] r_w_addr;
    logic [ADDR_W-1:0] r_r_addr;
    logic [DATA_W-1:0] r_w_d;
    logic [2:0]        r_starve;
    logic [NUM_WR-1:0] r_wr_done;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_addr_err;

    logic [NUM_WR-1:0] w_wr_req_eff;
    logic              w_rd_req_eff;
    logic [NUM_WR-1:0] w_grant;
    logic              w_any_wr;
    logic              w_grant_rd;
    logic              w_grant_wr;
    logic              w_decide;
    logic [ADDR_W-1:0] w_wr_addr_sel;
    logic [DATA_W-1:0] w_wr_data_sel;
    logic [ADDR_W-1:0] w_win_addr;
    logic              w_bank_err;
    logic              w_op_done;

    // A requester whose completion pulse is showing this cycle still holds
    // its request line; mask it so the same transaction is not re-granted.
    assign w_wr_req_eff = wr_req & ~r_wr_done;
    assign w_rd_req_eff = rd_req & ~r_rd_valid;

    rr_arbiter #(
        .NUM_WR    (NUM_WR)
    ) u_rr_arbiter (
        .clock     (clock),
        .reset     (reset),
        .i_req     (w_wr_req_eff),
        .i_advance ((r_state == ST_IDLE) && w_grant_wr),
        .o_grant   (w_grant),
        .o_any     (w_any_wr)
    );

    // Reader wins if it has been starved, otherwise only when writers are quiet.
    assign w_grant_rd = w_rd_req_eff && ((r_starve >= 3'(STARVE_LIMIT)) || !w_any_wr);
    assign w_grant_wr = w_any_wr && !w_grant_rd;
    assign w_decide   = (r_state == ST_IDLE) && (w_grant_rd || w_grant_wr);

    always_comb begin
        w_wr_addr_sel = '0;
        w_wr_data_sel = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (w_grant[k]) begin
                w_wr_addr_sel = wr_addr[k*ADDR_W +: ADDR_W];
                w_wr_data_sel = wr_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_win_addr = w_grant_rd ? rd_addr : w_wr_addr_sel;
    assign w_bank_err = bank_is_bad(w_win_addr[BANK_MSB:BANK_LSB]);
    assign w_op_done  = r_is_rd ? sram_d_ready : sram_w_done;

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next state. A bad-bank winner completes straight from IDLE.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_decide && !w_bank_err) w_next_state = ST_ISSUE;
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT:  if (w_op_done) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        sram_w_en = 1'b0;
        sram_r_en = 1'b0;
        if (r_state == ST_ISSUE) begin
            sram_w_en = !r_is_rd;
            sram_r_en = r_is_rd;
        end
    end

    // Operand registers and starvation counter, loaded at the IDLE decision.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_is_rd  <= 1'b0;
            r_win_oh <= '0;
            r_w_addr <= '0;
            r_r_addr <= '0;
            r_w_d    <= '0;
            r_starve <= '0;
        end else if (w_decide) begin
            r_is_rd  <= w_grant_rd;
            r_win_oh <= w_grant_rd ? '0 : w_grant;
            if (w_grant_rd) begin
                r_r_addr <= rd_addr;
                r_starve <= '0;
            end else begin
                r_w_addr <= w_wr_addr_sel;
                r_w_d    <= w_wr_data_sel;
                if (w_rd_req_eff) begin
                    r_starve <= starve_inc(r_starve);
                end
            end
        end
    end

    // Completion pulses: from WAIT on the controller strobe, or straight
    // after the decision for a bad-bank request (read data forced to 0).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_done  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_wr_done  <= '0;
            r_rd_valid <= 1'b0;
            r_addr_err <= 1'b0;
            if (w_decide && w_bank_err) begin
                r_addr_err <= 1'b1;
                if (w_grant_rd) begin
                    r_rd_valid <= 1'b1;
                    r_rd_data  <= '0;
                end else begin
                    r_wr_done  <= w_grant;
                end
            end else if ((r_state == ST_WAIT) && w_op_done) begin
                if (r_is_rd) begin
                    r_rd_valid <= 1'b1;
                    r_rd_data  <= sram_r_d;
                end else begin
                    r_wr_done  <= r_win_oh;
                end
            end
        end
    end

    assign wr_done     = r_wr_done;
    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_rd_data;
    assign addr_err    = r_addr_err;
    assign sram_w_addr = r_w_addr;
    assign sram_r_addr = r_r_addr;
    assign sram_w_d    = r_w_d;

`ifdef OSRAM_ARB_PERF_CNT_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    logic [31:0] r_perf_wr;
    logic [31:0] r_perf_rd;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_wr    <= '0;
            r_perf_rd    <= '0;
            r_perf_stall <= '0;
        end else begin
            if ((r_state == ST_WAIT) && w_op_done && !r_is_rd) r_perf_wr <= sat_inc32(r_perf_wr);
            if ((r_state == ST_WAIT) && w_op_done &&  r_is_rd) r_perf_rd <= sat_inc32(r_perf_rd);
            if ((r_state != ST_IDLE) && ((|wr_req) || rd_req)) r_perf_stall <= sat_inc32(r_perf_stall);
        end
    end

    assign perf_wr_cnt    = r_perf_wr;
    assign perf_rd_cnt    = r_perf_rd;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
